// File: rtl/dnn_layer_sched.sv
// Two-layer MLP inference sequencer: neuron-serial MAC, bias/ReLU
// writeback, hidden activation store and output argmax.
module dnn_layer_sched #(
    parameter int INPUT_SIZE     = 784,
    parameter int HIDDEN_NEURONS = 10,
    parameter int OUTPUT_NEURONS = 10,
    parameter int DATA_W         = 16,
    parameter int FRAC_BITS      = 8,
    parameter int ACC_W          = 48,
    localparam int IN_AW = $clog2(INPUT_SIZE),
    localparam int W_AW  = $clog2(HIDDEN_NEURONS * INPUT_SIZE),
    localparam int B_AW  = $clog2(HIDDEN_NEURONS),
    localparam int D_W   = $clog2(OUTPUT_NEURONS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [D_W-1:0]    final_digit,
    output logic              rd_en,
    output logic              layer,
    output logic [IN_AW-1:0]  in_addr,
    output logic [W_AW-1:0]   w_addr,
    output logic [B_AW-1:0]   bias_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] w_data,
    input  logic [DATA_W-1:0] bias_data
);

    if (ACC_W < 2 * DATA_W + $clog2(INPUT_SIZE) + 1) begin : g_acc_chk
        $error("ACC_W too narrow for a full-length dot product");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_H_MAC, S_H_DRAIN, S_H_WB,
        S_O_MAC, S_O_DRAIN, S_O_WB, S_DONE
    } state_t;

    localparam logic [DATA_W-1:0] HMAX = {1'b0, {(DATA_W-1){1'b1}}};

    state_t state, state_nxt;

    logic [IN_AW-1:0] k;
    logic [B_AW-1:0]  n;
    logic             o_phase;
    logic             is_mac;
    logic             k_last;
    logic             n_last;

    logic                     mac_v;
    logic                     clr_d;
    logic        [DATA_W-1:0] op_d;
    logic signed [DATA_W-1:0] opnd;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  wb_sum;
    logic signed [ACC_W-1:0]  shifted;
    logic        [DATA_W-1:0] hid_val;
    logic signed [ACC_W-1:0]  best_val;
    logic        [D_W-1:0]    best_idx;
    logic                     better;

    logic [DATA_W-1:0] hidden_store [HIDDEN_NEURONS];

    assign o_phase = (state == S_O_MAC) || (state == S_O_DRAIN) ||
                     (state == S_O_WB);
    assign is_mac  = (state == S_H_MAC) || (state == S_O_MAC);
    assign k_last  = o_phase ? (k == IN_AW'(HIDDEN_NEURONS - 1))
                             : (k == IN_AW'(INPUT_SIZE - 1));
    assign n_last  = o_phase ? (n == B_AW'(OUTPUT_NEURONS - 1))
                             : (n == B_AW'(HIDDEN_NEURONS - 1));

    assign layer     = o_phase;
    assign bias_addr = n;
    assign in_addr   = (state == S_H_MAC) ? k : '0;
    assign w_addr    = o_phase
        ? W_AW'(n) * W_AW'(HIDDEN_NEURONS) + W_AW'(k)
        : W_AW'(n) * W_AW'(INPUT_SIZE) + W_AW'(k);

    // Operand arrives one cycle after its address, from memory or the store.
    assign opnd     = o_phase ? $signed(op_d) : $signed(in_data);
    assign prod     = opnd * $signed(w_data);
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W-FRAC_BITS){bias_data[DATA_W-1]}},
                       bias_data, {FRAC_BITS{1'b0}}};
    assign wb_sum   = acc + bias_ext;
    assign shifted  = wb_sum >>> FRAC_BITS;
    assign hid_val  = wb_sum[ACC_W-1] ? '0
                    : (|shifted[ACC_W-1:DATA_W-1]) ? HMAX
                    : shifted[DATA_W-1:0];
    assign better   = (n == '0) || (wb_sum > best_val);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and control strobes.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        rd_en     = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_H_MAC;
            end
            S_H_MAC: begin
                rd_en = 1'b1;
                if (k_last) state_nxt = S_H_DRAIN;
            end
            S_H_DRAIN: state_nxt = S_H_WB;
            S_H_WB:    state_nxt = n_last ? S_O_MAC : S_H_MAC;
            S_O_MAC: begin
                rd_en = 1'b1;
                if (k_last) state_nxt = S_O_DRAIN;
            end
            S_O_DRAIN: state_nxt = S_O_WB;
            S_O_WB:    state_nxt = n_last ? S_DONE : S_O_MAC;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Fan-in index k and neuron index n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= '0;
            n <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    k <= '0;
                    n <= '0;
                end
                S_H_MAC, S_O_MAC: k <= k_last ? '0 : k + IN_AW'(1);
                S_H_WB, S_O_WB:   n <= n_last ? '0 : n + B_AW'(1);
                default: ;
            endcase
        end
    end

    // MAC pipeline: accumulate the product of the previous cycle's issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_v <= 1'b0;
            clr_d <= 1'b0;
            op_d  <= '0;
            acc   <= '0;
        end else begin
            mac_v <= is_mac;
            clr_d <= is_mac && (k == '0);
            op_d  <= hidden_store[k[B_AW-1:0]];
            if (mac_v) acc <= (clr_d ? '0 : acc) + prod_ext;
        end
    end

    // Hidden writeback and running argmax over output logits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIDDEN_NEURONS; i++) hidden_store[i] <= '0;
            best_val    <= '0;
            best_idx    <= '0;
            final_digit <= '0;
        end else if (state == S_H_WB) begin
            hidden_store[n] <= hid_val;
        end else if (state == S_O_WB) begin
            if (better) begin
                best_val <= wb_sum;
                best_idx <= D_W'(n);
            end
            if (n_last) final_digit <= better ? D_W'(n) : best_idx;
        end
    end

endmodule

// File: tb/tb_dnn_layer_sched.sv
// Bench for dnn_layer_sched: memory models, a dot-product reference model
// and a per-cycle compare of control, addresses and final_digit.
module tb_dnn_layer_sched;

    localparam int IS  = 784;
    localparam int HN  = 10;
    localparam int ON  = 10;
    localparam int LAT = HN * (IS + 2) + ON * (HN + 2);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, rd_en, layer;
    logic [3:0]  final_digit;
    logic [9:0]  in_addr;
    logic [12:0] w_addr;
    logic [3:0]  bias_addr;
    logic [15:0] in_data = '0;
    logic [15:0] w_data = '0;
    logic [15:0] bias_data = '0;

    logic signed [15:0] img [IS];
    logic signed [15:0] w_h [HN*IS];
    logic signed [15:0] w_o [ON*HN];
    logic signed [15:0] b_h [HN];
    logic signed [15:0] b_o [ON];

    int       n_cmp = 0;
    int       n_bad = 0;
    int       edge_cnt = 0;
    bit       m_run = 1'b0;
    int       m_r = 0;
    int       m_exp = 0;
    logic [3:0] m_digit = '0;

    dnn_layer_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .final_digit(final_digit),
        .rd_en(rd_en), .layer(layer), .in_addr(in_addr),
        .w_addr(w_addr), .bias_addr(bias_addr),
        .in_data(in_data), .w_data(w_data), .bias_data(bias_data)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories, one cycle of latency.
    always @(posedge clk) begin
        if (rd_en) begin
            in_data   <= img[in_addr];
            bias_data <= layer ? b_o[bias_addr] : b_h[bias_addr];
            if (layer) w_data <= w_o[w_addr];
            else       w_data <= w_h[w_addr];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     nm, act, exp, edge_cnt);
        end
    endtask

    function automatic int model_digit();
        longint h [HN];
        longint s, best;
        int bi;
        for (int n = 0; n < HN; n++) begin
            s = 0;
            for (int k = 0; k < IS; k++)
                s += longint'(img[k]) * longint'(w_h[n*IS+k]);
            s += longint'(b_h[n]) * 256;
            if (s < 0) s = 0;
            s = s / 256;
            if (s > 32767) s = 32767;
            h[n] = s;
        end
        bi = 0;
        best = 0;
        for (int c = 0; c < ON; c++) begin
            s = longint'(b_o[c]) * 256;
            for (int j = 0; j < HN; j++)
                s += h[j] * longint'(w_o[c*HN+j]);
            if (c == 0 || s > best) begin
                best = s;
                bi = c;
            end
        end
        return bi;
    endfunction

    // Model: run position m_r counts edges since the accepting edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run   = 1'b0;
            m_r     = 0;
            m_digit = '0;
        end else begin
            edge_cnt++;
            if (m_run) begin
                if (m_r == LAT) m_run = 1'b0;
                else begin
                    m_r++;
                    if (m_r == LAT) m_digit = 4'(m_exp);
                end
            end else if (start) begin
                m_run = 1'b1;
                m_r   = 0;
                m_exp = model_digit();
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        int nn, kk, rr;
        bit erd, elay;
        logic [9:0]  eia;
        logic [12:0] ewa;
        logic [3:0]  eba;
        erd = 0; elay = 0; eia = '0; ewa = '0; eba = '0;
        if (m_run && m_r < HN * (IS + 2)) begin
            nn = m_r / (IS + 2);
            kk = m_r % (IS + 2);
            if (kk < IS) begin
                erd = 1; elay = 0;
                eia = 10'(kk); ewa = 13'(nn * IS + kk); eba = 4'(nn);
            end
        end else if (m_run && m_r < LAT) begin
            rr = m_r - HN * (IS + 2);
            nn = rr / (HN + 2);
            kk = rr % (HN + 2);
            if (kk < HN) begin
                erd = 1; elay = 1;
                eia = '0; ewa = 13'(nn * HN + kk); eba = 4'(nn);
            end
        end
        chk("ctrl", 64'({busy, done, rd_en}),
            64'({m_run, m_run && (m_r == LAT), erd}));
        if (erd)
            chk("addr", 64'({layer, in_addr, w_addr, bias_addr}),
                64'({elay, eia, ewa, eba}));
        chk("digit", 64'(final_digit), 64'(m_digit));
    end

    task automatic clear_mem();
        foreach (img[i]) img[i] = '0;
        foreach (w_h[i]) w_h[i] = '0;
        foreach (w_o[i]) w_o[i] = '0;
        foreach (b_h[i]) b_h[i] = '0;
        foreach (b_o[i]) b_o[i] = '0;
    endtask

    task automatic start_run(input bit hold, output int s);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 s = edge_cnt;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input bit pulse,
                             input int s, output int d);
        bit found;
        found = 0;
        d = 0;
        for (int i = 0; i < LAT + 100 && !found; i++) begin
            @(negedge clk);
            if (pulse) start = (i == 50 || i == 4000);
            if (done) begin
                found = 1;
                d = edge_cnt;
            end
        end
        chk({nm, "_seen"}, 64'(found), 64'(1));
        if (found) begin
            if (s >= 0) chk({nm, "_lat"}, 64'(d - s), 64'(7980));
            @(negedge clk);
            chk({nm, "_width"}, 64'(done), 64'(0));
        end
    endtask

    initial begin
        int s, d, d1, d2;
        logic [3:0] rnd_digit;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rd", 64'(rd_en), 64'(0));
        chk("rst_digit", 64'(final_digit), 64'(0));
        chk("rst_waddr", 64'(w_addr), 64'(0));
        #2 rst_n = 1'b1;

        // Only output bias 7 set.
        clear_mem();
        b_o[7] = 16'sd5;
        start_run(0, s);
        wait_done("t1", 0, s, d);
        chk("t1_digit", 64'(final_digit), 64'(7));

        // All zero: tie resolved to class 0; start pulses ignored.
        clear_mem();
        start_run(0, s);
        wait_done("t2", 1, s, d);
        chk("t2_digit", 64'(final_digit), 64'(0));
        repeat (20) @(negedge clk);

        // Saturated hidden layer.
        clear_mem();
        foreach (img[i]) img[i] = 16'sh7FFF;
        foreach (w_h[i]) w_h[i] = 16'sh7FFF;
        for (int j = 0; j < HN; j++) w_o[5*HN+j] = 16'sd1;
        b_o[3] = 16'sd1000;
        start_run(0, s);
        wait_done("t3a", 0, s, d);
        chk("t3a_digit", 64'(final_digit), 64'(5));

        // ReLU clamps every hidden neuron to zero.
        foreach (w_h[i]) w_h[i] = 16'sh8001;
        start_run(0, s);
        wait_done("t3b", 0, s, d);
        chk("t3b_digit", 64'(final_digit), 64'(3));

        // Random data, uninterrupted.
        clear_mem();
        foreach (img[i]) img[i] = 16'($urandom_range(0, 255));
        foreach (w_h[i]) w_h[i] = 16'(int'($urandom_range(0, 31)) - 16);
        foreach (w_o[i]) w_o[i] = 16'(int'($urandom_range(0, 31)) - 16);
        foreach (b_h[i]) b_h[i] = 16'(int'($urandom_range(0, 400)) - 200);
        foreach (b_o[i]) b_o[i] = 16'(int'($urandom_range(0, 200)) - 100);
        start_run(0, s);
        wait_done("rnd", 0, s, d);
        rnd_digit = final_digit;

        // Abort mid hidden layer, then rerun the same data.
        start_run(0, s);
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_busy", 64'(busy), 64'(0));
        chk("t4_rd", 64'(rd_en), 64'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        start_run(0, s);
        wait_done("t4", 0, s, d);
        chk("t4_digit", 64'(final_digit), 64'(rnd_digit));

        // start held high: back-to-back runs.
        clear_mem();
        b_o[2] = 16'sd9;
        start_run(1, s);
        wait_done("t6a", 0, s, d1);
        wait_done("t6b", 0, -1, d2);
        start = 1'b0;
        chk("t6_gap", 64'(d2 - d1), 64'(7982));
        chk("t6_digit", 64'(final_digit), 64'(2));

        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
